// File: rtl/serial_ones_counter.sv
// serial_ones_counter
//
// Counts the 1-bits of a parallel word by shifting it out one bit per rising
// edge of a slow, divided clock so each step can be watched on LEDs. The
// whole block runs on the fast board clock. The slow clock is only sampled as
// data: it is synchronised, then edge-detected into a one-cycle step strobe.
//
// Ports:
//   clock_in   in   fast board clock; all state changes on its rising edge
//   reset_n    in   asynchronous active-low reset
//   slow_clk   in   divided clock, asynchronous to clock_in
//   start      in   level; begins a scan of data_in when the block is idle
//   data_in    in   [WIDTH] word to scan, captured only on an accepted start
//   busy       out  high while a scan is loading, shifting or finishing
//   done       out  one-cycle pulse when the scan completes
//   count      out  [CNT_W] number of 1s seen so far
//   cur_bit    out  next bit to be counted (LSB of the shift register)
//   bits_left  out  [CNT_W] bits still to be examined
//
// CNT_W must satisfy 2**CNT_W > WIDTH so count and bits_left never wrap.

module serial_ones_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             slow_clk,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             cur_bit,
    output logic [CNT_W-1:0] bits_left
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             step;

    // Two flops bring slow_clk into the clock_in domain; the third keeps the
    // previous synchronised value so a rising edge is seen exactly once, no
    // matter how long slow_clk then stays high.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= slow_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign step = s2 & ~s3;

    // The LSB of the shift register is already a flop, so the displayed bit
    // stays glitch-free without an extra register.
    assign cur_bit = shreg[0];

    // Scan controller. busy and done are driven alongside the state so they
    // come straight from flops. LOAD is a deliberate one-cycle gap: a step
    // landing there is discarded, so every scan consumes WIDTH fresh steps.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shreg     <= '0;
            count     <= '0;
            bits_left <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg     <= data_in;
                        count     <= '0;
                        bits_left <= CNT_W'(WIDTH);
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end

                LOAD: begin
                    state <= SHIFT;
                end

                SHIFT: begin
                    if (step) begin
                        count     <= count + CNT_W'(shreg[0]);
                        shreg     <= shreg >> 1;
                        bits_left <= bits_left - CNT_W'(1);
                        if (bits_left == CNT_W'(1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_ones_counter.md
Name: serial_ones_counter

Overview:
- Counts the 1-bits in a parallel word by shifting it out one bit per tick of the divided slow clock, so a human can watch each step on LEDs.
- Sits directly downstream of the clock divider and consumes its slow square-wave output.
- Everything runs on the fast board clock; the slow clock is never used as a clock. It is synchronised and edge-detected into a one-cycle step strobe.
- Presents a running count, the bit under test, bits remaining, and a done pulse to the display logic.

Parameters:
- WIDTH, 8, width of the word to scan.
- CNT_W, 4, width of count and bits_left; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock_in  input  1  fast board clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- slow_clk  input  1  divided clock from the divider; treated as asynchronous data.
- start  input  1  level sampled each cycle; loads data_in and begins a scan when in IDLE.
- data_in  input  WIDTH  word to scan; sampled only on an accepted start.
- busy  output  1  high in LOAD/SHIFT/DONE states.
- done  output  1  one-cycle pulse at scan completion.
- count  output  CNT_W  running number of 1s seen so far.
- cur_bit  output  1  LSB of the internal shift register (next bit to be counted).
- bits_left  output  CNT_W  bits still to be examined.

Behaviour:
- Reset (reset_n low, async): state=IDLE, shift reg=0, count=0, bits_left=0, busy=0, done=0, sync flops s1/s2/s3=0. All outputs are registered.
- Step generation:
  - s1<=slow_clk, s2<=s1, s3<=s2 every cycle.
  - step = s2 & ~s3 (combinational).
  - One step per slow_clk rising edge, regardless of how long slow_clk stays high.
  - step is first high in the cycle after the 2nd clock_in edge that samples slow_clk high; state updates on the 3rd edge.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE: busy=0. If start=1: shreg<=data_in, count<=0, bits_left<=WIDTH, go to LOAD.
  - LOAD: busy=1, one cycle, then go to SHIFT. Steps arriving in LOAD are dropped.
  - SHIFT: on step: count<=count+shreg[0], shreg<=shreg>>1 (zero fill), bits_left<=bits_left-1. If bits_left==1 on that step, go to DONE. No step means hold.
  - DONE: done=1 for exactly this one cycle, busy=1, then go to IDLE.
- start is ignored outside IDLE. A held start re-triggers on the first IDLE cycle after DONE.
- count and bits_left hold their final values in IDLE until the next accepted start.
- Arithmetic: count never exceeds WIDTH, so no wrap. bits_left never decrements below 0.
- Latency: a scan takes exactly WIDTH steps after LOAD. done asserts the cycle after the WIDTH-th step updates state.
- Reset mid-scan: returns immediately to reset values. The bench sees no done pulse.
- WIDTH=1: a single step goes straight to DONE.

Test Plan:
- WIDTH=8, data_in=8'hB5, start pulse, 8 slow_clk rising edges -> count steps 1,1,2,2,3,4,4,5; final count=5; done pulses one cycle; busy falls next cycle; bits_left=0.
- data_in=8'h00 then 8'hFF -> final count=0 and count=8 respectively. No overflow at CNT_W=4. count resets to 0 at the second start.
- slow_clk held high for 50 clock_in cycles during SHIFT -> exactly one increment of the 8-bit scan. slow_clk rising edge -> count changes exactly 3 clock_in edges later.
- start=1 and data_in=8'h0F asserted mid-scan of 8'hF0 -> ignored; final count=4 from 8'hF0. start held high through DONE -> new scan of 8'h0F begins in IDLE.
- reset_n pulled low after 4 steps of 8'hFF (count=4) -> all outputs 0 asynchronously, no done. After release with start low, the block stays IDLE despite continued slow_clk edges.
- slow_clk rising edge timed so step lands in the LOAD cycle -> step dropped; the scan still needs 8 further steps; final count correct.
